// File: rtl/vga_text_render.sv
// Text-mode pixel stage for the VGA console: maps the beam position to a text cell,
// fetches the glyph row from an external font ROM and emits RGB222 with delay-matched syncs.
module vga_text_render #(
    parameter int COL_BITS   = 4,
    parameter int ROW_BITS   = 2,
    parameter int BLINK_BITS = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [5:0]                   x_hi,
    input  logic [4:0]                   x_lo,
    input  logic [4:0]                   y_hi,
    input  logic [5:0]                   y_lo,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic                         blank_in,
    input  logic                         wr_en,
    input  logic [COL_BITS+ROW_BITS-1:0] wr_addr,
    input  logic [7:0]                   wr_data,
    input  logic [5:0]                   fg,
    input  logic [5:0]                   bg,
    input  logic                         cursor_en,
    input  logic [COL_BITS+ROW_BITS-1:0] cursor_addr,
    output logic [6:0]                   font_char,
    output logic [3:0]                   font_row,
    input  logic [7:0]                   font_bits,
    output logic [1:0]                   r,
    output logic [1:0]                   g,
    output logic [1:0]                   b,
    output logic                         hsync_out,
    output logic                         vsync_out
);
    localparam int AW    = COL_BITS + ROW_BITS;
    localparam int CELLS = 1 << AW;
    localparam logic [6:0] COLS_LIM = 7'(1 << COL_BITS);
    localparam logic [5:0] ROWS_LIM = 6'(1 << ROW_BITS);

    logic [7:0]            text_buf [CELLS];
    logic [AW-1:0]         rd_addr;
    logic [7:0]            code_q;
    logic [2:0]            gcol_q;
    logic                  in_win_q;
    logic                  blank_q;
    logic                  cur_hit_q;
    logic [5:0]            rgb_q;
    logic                  hs_d1, hs_d2, vs_d1, vs_d2;
    logic                  vsync_prev;
    logic [BLINK_BITS-1:0] frame_cnt;
    logic                  glyph_bit;
    logic                  blink_phase;
    logic                  pixel_on;
    logic [5:0]            rgb_next;
    logic                  unused_bits;

    // Sub-pixel bits only select within a 4x4 scaled glyph dot.
    assign unused_bits = ^{x_lo[1:0], y_lo[1:0]};

    assign rd_addr = {y_hi[ROW_BITS-1:0], x_hi[COL_BITS-1:0]};

    // Registered read sees the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) text_buf[i] <= 8'h00;
        end else if (wr_en) begin
            text_buf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q    <= 8'h00;
            gcol_q    <= 3'd0;
            in_win_q  <= 1'b0;
            blank_q   <= 1'b0;
            cur_hit_q <= 1'b0;
            font_char <= 7'd0;
            font_row  <= 4'd0;
        end else begin
            code_q    <= text_buf[rd_addr];
            gcol_q    <= x_lo[4:2];
            in_win_q  <= !blank_in && ({1'b0, x_hi} < COLS_LIM) && ({1'b0, y_hi} < ROWS_LIM);
            blank_q   <= blank_in;
            cur_hit_q <= cursor_en && (rd_addr == cursor_addr);
            font_char <= text_buf[rd_addr][6:0];
            font_row  <= y_lo[5:2];
        end
    end

    assign glyph_bit   = font_bits[3'd7 - gcol_q];
    assign blink_phase = frame_cnt[BLINK_BITS-1];
    assign pixel_on    = glyph_bit ^ code_q[7] ^ (cur_hit_q & blink_phase);

    always_comb begin
        rgb_next = 6'd0;
        if (blank_q)        rgb_next = 6'd0;
        else if (!in_win_q) rgb_next = bg;
        else                rgb_next = pixel_on ? fg : bg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q <= 6'd0;
            hs_d1 <= 1'b1;
            hs_d2 <= 1'b1;
            vs_d1 <= 1'b0;
            vs_d2 <= 1'b0;
        end else begin
            rgb_q <= rgb_next;
            hs_d1 <= hsync_in;
            hs_d2 <= hs_d1;
            vs_d1 <= vsync_in;
            vs_d2 <= vs_d1;
        end
    end

    // Frame counter advances once per vsync assertion; its MSB is the cursor blink phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_prev <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vsync_prev <= vsync_in;
            if (vsync_in && !vsync_prev) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign r         = rgb_q[5:4];
    assign g         = rgb_q[3:2];
    assign b         = rgb_q[1:0];
    assign hsync_out = hs_d2;
    assign vsync_out = vs_d2;
endmodule
